seq_rb_divider: RTL and testbench
=================================

Name: seq_rb_divider

Overview:
- Sequential radix-2 restoring divider; inverse of the generic row-bypass array multiplier.
- Divides an (m+n)-bit product-width dividend by an n-bit divisor, producing an m-bit quotient and an n-bit remainder.
- Low-power flavour: zero-row bypass terminates iteration early once the partial remainder and the remaining dividend bits are all zero.
- Sits beside the multiplier so `p = a*x` can be round-tripped: `p / x` returns `a` with remainder 0.

Parameters:
- m, 8, quotient width (multiplier operand `a` width)
- n, 8, divisor and remainder width (multiplier operand `x` width)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted on an edge where start=1 and busy=0
- dividend  input  m+n  dividend, sampled at accept
- divisor  input  n  divisor, sampled at accept
- busy  output  1  high in RUN and DONE states
- done  output  1  high for exactly one cycle (DONE state)
- quotient  output  m  result; valid when done=1, held until the next accept
- remainder  output  n  result; valid when done=1, held until the next accept
- div_zero  output  1  divisor was 0; valid with done
- overflow  output  1  quotient would not fit in m bits; valid with done
- steps  output  $clog2(m+1)  number of RUN cycles used; valid with done

Behaviour:
- Reset (synchronous, active-high)
  - Effective at the next edge; overrides everything, including an operation in progress.
  - State goes to IDLE. All outputs are 0: busy, done, quotient, remainder, div_zero, overflow, steps.
  - An aborted operation produces no done pulse.
- States and transitions
  - IDLE, RUN, DONE; encoding lives in the package.
  - IDLE: on start, latch operands and go to RUN or DONE per the rules below.
  - DONE lasts one cycle, then returns to IDLE.
  - start while busy=1 is ignored. start during DONE is also ignored; accept resumes in the following IDLE cycle.
- Accept edge E0, checked in priority order:
  - divisor==0: go to DONE. div_zero=1, overflow=0, quotient all ones, remainder = dividend[n-1:0], steps=0.
  - Else if dividend[m+n-1:m] >= divisor: go to DONE. overflow=1, quotient all ones, remainder=0, steps=0.
  - Else go to RUN. Partial remainder R = dividend[m+n-1:m] (n+1 bits internally). Shift register D = dividend[m-1:0]. Step count k=0.
- RUN, one quotient bit per edge, MSB first
  - T = {R, D[msb]}.
  - If T >= divisor: q bit = 1 and R = T - divisor; else q bit = 0 and R = T.
  - Shift D left; k = k+1.
  - Go to DONE when k==m.
  - Zero-row bypass: also go to DONE when the new R==0 and all remaining D bits are 0. Remaining quotient bits are zero-filled, i.e. quotient = collected bits << (m-k).
- Timing
  - Full-length operation: done is high in the cycle after edge E_m.
  - Latency from accept edge to the done cycle is k cycles, where 1 <= k <= m.
  - Special cases (div_zero, overflow) give done in the cycle after E0.
- Datapath
  - The subtractor is n+1 bits.
  - In IDLE/DONE the subtractor operand registers are held (not reloaded), so there is no toggling.
  - quotient, remainder, div_zero, overflow and steps update only on the edge entering DONE. They hold through IDLE and change no earlier than the next DONE entry.
  - Flags are cleared at accept.

Decomposition:
- Package `rb_div_pkg` holds:
  - state enum (IDLE, RUN, DONE)
  - the step-count width function `$clog2(m+1)`
- One natural sub-module: `rb_div_step`. It is combinational: (R, next dividend bit, divisor) -> (new R, q bit, zero flag). It is instantiated once; a future unrolled array version would reuse it.

Test Plan (m=8, n=8):
- Round trip: dividend=16'd32385 (255*127), divisor=127 -> quotient=255, remainder=0, steps=8, done exactly 8 cycles after the accept edge, single-cycle pulse.
- Zero-row bypass: dividend=16'h0100, divisor=2 -> quotient=8'h80, remainder=0, steps=1. Also dividend=0, divisor=5 -> quotient=0, remainder=0, steps=1.
- Remainder path: dividend=16'd1000, divisor=7 -> quotient=142, remainder=6, steps=8.
- Special cases: dividend=16'h1234, divisor=0 -> div_zero=1, quotient=8'hFF, remainder=8'h34, steps=0. dividend=16'h0500, divisor=5 -> overflow=1, quotient=8'hFF, remainder=0. In both cases done appears one cycle after accept.
- Handshake and reset:
  - start held high for a whole operation -> exactly one accept; re-accept no earlier than the IDLE cycle after done.
  - rst asserted at RUN step 4 -> at the next edge busy=0 and all outputs 0, with no done pulse.
  - New operation 32385/127 after reset -> correct result.
- Sweep versus multiplier: for every x in {8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F} and a in {1, 128, 255}, divide a*x by x -> quotient=a, remainder=0.

Source files
------------

// File: rtl/rb_div_pkg.sv
// Shared types and helpers for the sequential row-bypass restoring divider.
package rb_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the step counter, which must hold every value from 0 to m.
   function automatic int step_width(input int m);
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rb_div_step.sv
// One restoring-division row: shift in a dividend bit, trial-subtract, keep or restore.
module rb_div_step #(
   parameter int n = 8
) (
   input  logic [n-1:0] r_in,
   input  logic         bit_in,
   input  logic [n-1:0] divisor,
   output logic [n-1:0] r_out,
   output logic         q_bit,
   output logic         r_zero
);

   logic [n:0] diff;

   // NOTE: every output is given a value on every path, so no latch can be inferred.
   always_comb begin
      diff   = {r_in, bit_in} - {1'b0, divisor};
      // No borrow out of the n+1-bit subtractor means T >= divisor.
      q_bit  = ~diff[n];
      r_out  = q_bit ? diff[n-1:0] : {r_in[n-2:0], bit_in};
      r_zero = (r_out == '0);
   end

endmodule

// File: rtl/seq_rb_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, with zero-row early exit.
module seq_rb_divider
   import rb_div_pkg::*;
#(
   parameter int m = 8,
   parameter int n = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [m+n-1:0]            dividend,
   input  logic [n-1:0]              divisor,
   output logic                      busy,
   output logic                      done,
   output logic [m-1:0]              quotient,
   output logic [n-1:0]              remainder,
   output logic                      div_zero,
   output logic                      overflow,
   output logic [step_width(m)-1:0]  steps
);

   localparam int sw = step_width(m);

   state_t         state;
   state_t         state_nx;
   logic           accept;
   logic           is_zero;
   logic           is_ovf;
   logic           finish;

   // The partial remainder stays below the divisor, so n bits hold it; T is n+1 bits.
   logic [n-1:0]   r_q;
   logic [n-1:0]   dv_q;
   logic [m-1:0]   d_q;
   logic [m-2:0]   q_acc;
   logic [sw-1:0]  k_q;

   logic [n-1:0]   r_nx;
   logic           q_bit;
   logic           r_zero;
   logic [m-1:0]   q_nx;
   logic [sw-1:0]  k_nx;

   assign is_zero = (divisor == '0);
   assign is_ovf  = (dividend[m+n-1:m] >= divisor);

   rb_div_step #(.n(n)) u_step (
      .r_in    (r_q),
      .bit_in  (d_q[m-1]),
      .divisor (dv_q),
      .r_out   (r_nx),
      .q_bit   (q_bit),
      .r_zero  (r_zero)
   );

   always_comb begin
      q_nx   = {q_acc, q_bit};
      k_nx   = k_q + 1'b1;
      // Stop early once nothing but zeros is left to divide.
      finish = (k_nx == sw'(m)) || (r_zero && (d_q[m-2:0] == '0));
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = (is_zero || is_ovf) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (finish) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Operand registers only move on accept and in RUN, keeping the subtractor quiet otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q       <= '0;
         dv_q      <= '0;
         d_q       <= '0;
         q_acc     <= '0;
         k_q       <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
         steps     <= '0;
      end else if (accept) begin
         div_zero <= 1'b0;
         overflow <= 1'b0;
         if (is_zero) begin
            div_zero  <= 1'b1;
            quotient  <= '1;
            remainder <= dividend[n-1:0];
            steps     <= '0;
         end else if (is_ovf) begin
            overflow  <= 1'b1;
            quotient  <= '1;
            remainder <= '0;
            steps     <= '0;
         end else begin
            dv_q  <= divisor;
            r_q   <= dividend[m+n-1:m];
            d_q   <= dividend[m-1:0];
            k_q   <= '0;
            q_acc <= '0;
         end
      end else if (state == RUN) begin
         r_q   <= r_nx;
         d_q   <= {d_q[m-2:0], 1'b0};
         q_acc <= q_nx[m-2:0];
         k_q   <= k_nx;
         if (finish) begin
            quotient  <= q_nx << (sw'(m) - k_nx);
            remainder <= r_nx;
            steps     <= k_nx;
         end
      end
   end

endmodule

// File: tb/tb_seq_rb_divider.sv
// Scoreboard bench for seq_rb_divider with m=8, n=8.
module tb_seq_rb_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        busy;
   logic        done;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        div_zero;
   logic        overflow;
   logic [3:0]  steps;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       ov;
      logic [3:0] st;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   seq_rb_divider #(.m(8), .n(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow),
      .steps     (steps)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Arithmetic reference: quotient/remainder by / and %, steps as the first k
   // where the consumed prefix divides evenly and every unconsumed bit is zero.
   function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
      exp_t e;
      int   dd_i;
      int   dv_i;
      e = '0;
      dd_i = int'(dd);
      dv_i = int'(dv);
      if (dv == 8'd0) begin
         e.dz = 1'b1;
         e.q  = 8'hFF;
         e.r  = dd[7:0];
      end else if (int'(dd[15:8]) >= dv_i) begin
         e.ov = 1'b1;
         e.q  = 8'hFF;
      end else begin
         e.q  = 8'(dd_i / dv_i);
         e.r  = 8'(dd_i % dv_i);
         e.st = 4'd8;
         for (int k = 1; k < 8; k++) begin
            if ((((dd_i >> (8 - k)) % dv_i) == 0) && ((dd_i & ((1 << (8 - k)) - 1)) == 0)) begin
               e.st = 4'(k);
               break;
            end
         end
      end
      return e;
   endfunction

   // Scoreboard monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pending op", cyc);
         end else begin
            mon_e = sb.pop_front();
            vectors++;
            if (quotient !== mon_e.q) begin
               miscompares++;
               $display("FAIL quotient: got %0h, want %0h", quotient, mon_e.q);
            end
            vectors++;
            if (remainder !== mon_e.r) begin
               miscompares++;
               $display("FAIL remainder: got %0h, want %0h", remainder, mon_e.r);
            end
            vectors++;
            if (div_zero !== mon_e.dz || overflow !== mon_e.ov) begin
               miscompares++;
               $display("FAIL flags: got dz=%0b ov=%0b, want dz=%0b ov=%0b", div_zero, overflow, mon_e.dz, mon_e.ov);
            end
            vectors++;
            if (steps !== mon_e.st) begin
               miscompares++;
               $display("FAIL steps: got %0d, want %0d", steps, mon_e.st);
            end
            vectors++;
            if (cyc != mon_e.cyc) begin
               miscompares++;
               $display("FAIL latency: got done at cycle %0d, want %0d", cyc, mon_e.cyc);
            end
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("FAIL busy_at_done: got %0b, want 1", busy);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is seen, or after the budget.
   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [15:0] dd, input logic [7:0] dv);
      exp_t e;
      bit   ok;
      @(negedge clk);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      e = model(dd, dv);
      e.cyc = cyc + 1 + int'(e.st);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_done(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL done_timeout: got no done for %0h/%0h, want done", dd, dv);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse: got done=%0b one cycle later, want 0", done);
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, quotient, remainder, div_zero, overflow, steps} !== 29'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0h r=%0h dz=%0b ov=%0b st=%0d, want all 0",
                  busy, done, quotient, remainder, div_zero, overflow, steps);
      end
      rst = 1'b0;
   endtask

   task automatic test_round_trip;
      run_op(16'd32385, 8'd127);
   endtask

   task automatic test_bypass;
      run_op(16'h0100, 8'd2);
      run_op(16'd0, 8'd5);
   endtask

   task automatic test_remainder;
      run_op(16'd1000, 8'd7);
      repeat (3) @(negedge clk);
      vectors++;
      if (quotient !== 8'd142 || remainder !== 8'd6) begin
         miscompares++;
         $display("FAIL result_hold: got q=%0d r=%0d, want q=142 r=6", quotient, remainder);
      end
   endtask

   task automatic test_special;
      run_op(16'h1234, 8'd0);
      run_op(16'h0500, 8'd5);
   endtask

   task automatic test_back_to_back;
      exp_t e;
      bit   ok;
      @(negedge clk);
      dividend = 16'd32385;
      divisor  = 8'd127;
      start    = 1'b1;
      e = model(16'd32385, 8'd127);
      e.cyc = cyc + 1 + int'(e.st);
      sb.push_back(e);
      @(negedge clk);
      wait_done(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL held_start_timeout: got no done, want done");
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL no_accept_in_done: got busy=%0b in cycle after done, want 0", busy);
      end
      e.cyc = cyc + 1 + int'(e.st);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reaccept: got busy=%0b after IDLE cycle, want 1", busy);
      end
      wait_done(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL reaccept_timeout: got no done, want done");
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      bit saw_done;
      @(negedge clk);
      dividend = 16'd32385;
      divisor  = 8'd127;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({busy, done, quotient, remainder, div_zero, overflow, steps} !== 29'd0) begin
         miscompares++;
         $display("FAIL abort_outputs: got busy=%0b done=%0b q=%0h r=%0h dz=%0b ov=%0b st=%0d, want all 0",
                  busy, done, quotient, remainder, div_zero, overflow, steps);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done) begin
         miscompares++;
         $display("FAIL abort_no_done: got done=1 after abort, want 0");
      end
      run_op(16'd32385, 8'd127);
   endtask

   task automatic test_sweep;
      logic [7:0] xs [9];
      logic [7:0] as [3];
      xs = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      as = '{8'd1, 8'd128, 8'd255};
      foreach (xs[i]) begin
         foreach (as[j]) begin
            run_op(16'(int'(as[j]) * int'(xs[i])), xs[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_trip();
      test_bypass();
      test_remainder();
      test_special();
      test_back_to_back();
      test_abort();
      test_sweep();
      repeat (2) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
